mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one multi-cycle memory port between the pipeline's imem (read-only) and dmem (read/write) requesters.
//  Sits between cpu and the unified memory/cache; one transaction outstanding at a time.
//  Registers the winner's request, issues it downstream, waits for mem_resp, routes rdata/resp back.
//  Sticky watchdog flag for a hung memory.
// PARAMETERS
//  TIMEOUT_CYC  1024  cycles in WAIT without mem_resp before timeout_err sets; 0 disables watchdog
// PORTS
//  clk          in   1   clock, all state on rising edge
//  rst          in   1   reset, asynchronous, active-low (0 = reset)
//  imem_addr    in   32  instruction fetch address
//  imem_rmask   in   4   fetch byte mask; nonzero = request pending
//  imem_rdata   out  32  fetch data, valid when imem_resp=1
//  imem_resp    out  1   fetch complete, 1-cycle pulse
//  dmem_addr    in   32  data address
//  dmem_rmask   in   4   load mask; nonzero = load pending
//  dmem_wmask   in   4   store mask; nonzero = store pending (never both masks nonzero)
//  dmem_wdata   in   32  store data
//  dmem_rdata   out  32  load data, valid when dmem_resp=1
//  dmem_resp    out  1   data op complete, 1-cycle pulse
//  mem_addr     out  32  downstream address, held from ISSUE through resp
//  mem_rmask    out  4   downstream read mask, nonzero only in ISSUE
//  mem_wmask    out  4   downstream write mask, nonzero only in ISSUE
//  mem_wdata    out  32  downstream write data, held from ISSUE through resp
//  mem_rdata    in   32  downstream read data, valid with mem_resp
//  mem_resp     in   1   downstream completion pulse
//  timeout_err  out  1   sticky watchdog flag
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE, addr/wdata/mask regs=0, last_grant=IMEM, wait_cnt=0,
//   timeout_err=0; all outputs 0.
//  FSM IDLE -> ISSUE -> WAIT -> IDLE.
//  IDLE: pending_i = |imem_rmask; pending_d = |dmem_rmask | |dmem_wmask.
//   Either pending -> latch winner's addr/masks/wdata (imem: wmask=0, wdata=0), record grant -> ISSUE.
//   Neither -> stay IDLE.
//  ISSUE (exactly 1 cycle): mem_rmask/mem_wmask = latched masks -> WAIT.
//   mem_resp during ISSUE is ignored.
//  WAIT: masks=0; addr/wdata still driven.
//   mem_resp=1 -> resp of granted side = 1 same cycle (combinational from mem_resp & state),
//   that side's rdata = mem_rdata, last_grant <= grant, -> IDLE.
//  rdata outputs: mem_rdata when that side's resp=1, else 0. Ungranted side's resp always 0.
//  Latency: request sampled in IDLE cycle N, mem masks in N+1, earliest resp N+2.
//   Back-to-back requests pay one IDLE cycle.
//  Requests are level: requester holds addr/mask until its resp. A request dropped before
//   grant is simply not served. Inputs are sampled only in IDLE; later changes are ignored.
//  Watchdog: wait_cnt clears on entering WAIT, increments each WAIT cycle without resp, saturates.
//   wait_cnt==TIMEOUT_CYC -> timeout_err<=1 (sticky until reset). FSM keeps waiting; no abort.
//  Reset mid-transaction: immediate IDLE; a late mem_resp arrives in IDLE and is dropped
//   (no requester resp).
// CONFIGURATION
//  MEMARB_RR_EN defined: simultaneous pending in IDLE -> grant the side != last_grant (round-robin);
//   first tie after reset goes to dmem (last_grant resets to IMEM).
//  MEMARB_RR_EN undefined: fixed priority, dmem always wins ties (pipeline stalls globally on dmem,
//   so imem starvation is bounded). last_grant is still maintained but unused.
//  Single-requester behaviour is identical in both builds.
// TESTING
//  1 imem only, addr=0x6000_0000, rmask=F, resp 3 cyc after ISSUE, rdata=0x0000_0013
//   -> mem_rmask=F for 1 cyc; imem_resp=1 with imem_rdata=0x13 once; dmem_resp stays 0.
//  2 dmem store addr=0x100, wmask=3, wdata=0xDEAD_BEEF -> mem_wmask=3, mem_rmask=0, mem_wdata held
//   until resp; dmem_resp pulse.
//  3 Both request every cycle, 4 transactions, fixed build -> grants D,D,D,D;
//   RR build -> grants D,I,D,I.
//  4 TIMEOUT_CYC=8, never assert mem_resp -> timeout_err rises after 8 WAIT cycles, stays 1;
//   later resp still completes the transaction.
//  5 rst=0 in WAIT, release, then mem_resp pulse -> no imem/dmem resp; next request issues normally.
//  6 mem_resp asserted in ISSUE cycle -> ignored; the real resp in WAIT completes exactly one transaction.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbitrates one multi-cycle memory port between imem (read) and dmem (read/write) requesters.
// Define MEMARB_RR_EN for round-robin tie-breaking; default build gives dmem fixed priority.
module mem_port_arbiter #(
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] imem_addr,
  input  logic [3:0]  imem_rmask,
  output logic [31:0] imem_rdata,
  output logic        imem_resp,
  input  logic [31:0] dmem_addr,
  input  logic [3:0]  dmem_rmask,
  input  logic [3:0]  dmem_wmask,
  input  logic [31:0] dmem_wdata,
  output logic [31:0] dmem_rdata,
  output logic        dmem_resp,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_rmask,
  output logic [3:0]  mem_wmask,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_resp,
  output logic        timeout_err
);
  localparam int CW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYC);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t        state_q, state_d;
  logic [31:0]   addr_q, addr_d, wdata_q, wdata_d;
  logic [3:0]    rmask_q, rmask_d, wmask_q, wmask_d;
  logic          grant_q, grant_d;          // 1 = dmem
  logic          last_grant_q, last_grant_d;
  logic [CW-1:0] wait_cnt_q, wait_cnt_d;
  logic          timeout_q, timeout_d;
  logic          pend_i, pend_d, pick_d, done;

  assign pend_i = |imem_rmask;
  assign pend_d = |dmem_rmask | |dmem_wmask;
  assign done   = (state_q == WAIT) && mem_resp;

`ifdef MEMARB_RR_EN
  assign pick_d = pend_d && (!pend_i || !last_grant_q);
`else
  assign pick_d = pend_d;
`endif

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rmask_d      = rmask_q;
    wmask_d      = wmask_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    wait_cnt_d   = wait_cnt_q;
    timeout_d    = timeout_q;
    case (state_q)
      IDLE: begin
        if (pend_i || pend_d) begin
          state_d = ISSUE;
          grant_d = pick_d;
          if (pick_d) begin
            addr_d  = dmem_addr;
            rmask_d = dmem_rmask;
            wmask_d = dmem_wmask;
            wdata_d = dmem_wdata;
          end else begin
            addr_d  = imem_addr;
            rmask_d = imem_rmask;
            wmask_d = 4'h0;
            wdata_d = 32'h0;
          end
        end
      end
      ISSUE: begin
        state_d    = WAIT;
        wait_cnt_d = '0;
      end
      WAIT: begin
        if (mem_resp) begin
          state_d      = IDLE;
          last_grant_d = grant_q;
        end else if (wait_cnt_q != CNT_MAX) begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
        // Watchdog only flags; the transaction is never aborted.
        if (TIMEOUT_CYC != 0 && wait_cnt_q == CNT_MAX) timeout_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      wdata_q      <= '0;
      rmask_q      <= '0;
      wmask_q      <= '0;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b0;
      wait_cnt_q   <= '0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rmask_q      <= rmask_d;
      wmask_q      <= wmask_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      wait_cnt_q   <= wait_cnt_d;
      timeout_q    <= timeout_d;
    end
  end

  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;
  assign mem_rmask   = (state_q == ISSUE) ? rmask_q : 4'h0;
  assign mem_wmask   = (state_q == ISSUE) ? wmask_q : 4'h0;
  assign imem_resp   = done && !grant_q;
  assign dmem_resp   = done && grant_q;
  assign imem_rdata  = imem_resp ? mem_rdata : 32'h0;
  assign dmem_rdata  = dmem_resp ? mem_rdata : 32'h0;
  assign timeout_err = timeout_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: per-cycle vector table plus multi-cycle sequences.
module tb_mem_port_arbiter;
  logic        clk = 1'b0, rst = 1'b0;
  logic [31:0] imem_addr = '0, dmem_addr = '0, dmem_wdata = '0, mem_rdata = '0;
  logic [3:0]  imem_rmask = '0, dmem_rmask = '0, dmem_wmask = '0;
  logic        mem_resp = 1'b0;
  logic [31:0] imem_rdata, dmem_rdata, mem_addr, mem_wdata;
  logic        imem_resp, dmem_resp, timeout_err;
  logic [3:0]  mem_rmask, mem_wmask;

  int n_chk = 0, n_fail = 0;

  mem_port_arbiter #(.TIMEOUT_CYC(8)) dut (
    .clk(clk), .rst(rst),
    .imem_addr(imem_addr), .imem_rmask(imem_rmask), .imem_rdata(imem_rdata), .imem_resp(imem_resp),
    .dmem_addr(dmem_addr), .dmem_rmask(dmem_rmask), .dmem_wmask(dmem_wmask), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
    .mem_addr(mem_addr), .mem_rmask(mem_rmask), .mem_wmask(mem_wmask), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  irm, drm, dwm;
    logic [31:0] ia, da, dwd;
    logic        mr;
    logic [31:0] mrd;
    logic [3:0]  erm, ewm;
    logic        ca;
    logic [31:0] ea, ewd;
    logic        eir;
    logic [31:0] eird;
    logic        edr;
    logic [31:0] edrd;
  } vec_t;

  vec_t tv[17];

  function automatic vec_t mk(input logic [3:0] irm, drm, dwm, input logic [31:0] ia, da, dwd,
                              input logic mr, input logic [31:0] mrd, input logic [3:0] erm, ewm,
                              input logic ca, input logic [31:0] ea, ewd, input logic eir,
                              input logic [31:0] eird, input logic edr, input logic [31:0] edrd);
    vec_t v;
    v.irm = irm; v.drm = drm; v.dwm = dwm; v.ia = ia; v.da = da; v.dwd = dwd;
    v.mr = mr; v.mrd = mrd; v.erm = erm; v.ewm = ewm; v.ca = ca; v.ea = ea; v.ewd = ewd;
    v.eir = eir; v.eird = eird; v.edr = edr; v.edrd = edrd;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [95:0] got, input logic [95:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic wait_issue(input string nm);
    bit seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk); #1;
      if ((mem_rmask | mem_wmask) != 4'h0) seen = 1;
    end
    if (!seen) chk({nm, "_issue_timeout"}, 96'd0, 96'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    imem_rmask = 0; dmem_rmask = 0; dmem_wmask = 0; mem_resp = 0; mem_rdata = 0;
    rst = 1'b0; #1;
    chk("reset_outputs", {mem_rmask, mem_wmask, imem_resp, dmem_resp, timeout_err, mem_addr,
                          mem_wdata, imem_rdata | dmem_rdata}, 96'd0);
    @(negedge clk); rst = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    logic [1:0] exp_g[4];
    logic [1:0] got_g;
    // imem fetch; dmem store; imem fetch with spurious resp in ISSUE and in IDLE
    tv[0]  = mk(4'hF,0,0, 32'h6000_0000,0,0, 0,0,         0,0, 0,0,0,                      0,0, 0,0);
    tv[1]  = mk(4'hF,0,0, 32'h6000_0000,0,0, 0,0,         4'hF,0, 1,32'h6000_0000,0,       0,0, 0,0);
    tv[2]  = mk(4'hF,0,0, 32'h6000_0000,0,0, 0,0,         0,0, 1,32'h6000_0000,0,          0,0, 0,0);
    tv[3]  = mk(4'hF,0,0, 32'h6000_0000,0,0, 0,0,         0,0, 1,32'h6000_0000,0,          0,0, 0,0);
    tv[4]  = mk(4'hF,0,0, 32'h6000_0000,0,0, 1,32'h13,    0,0, 1,32'h6000_0000,0,          1,32'h13, 0,0);
    tv[5]  = mk(0,0,0, 0,0,0, 0,0,                        0,0, 0,0,0,                      0,0, 0,0);
    tv[6]  = mk(0,0,4'h3, 0,32'h100,32'hDEAD_BEEF, 0,0,   0,0, 0,0,0,                      0,0, 0,0);
    tv[7]  = mk(0,0,4'h3, 0,32'h100,32'hDEAD_BEEF, 0,0,   0,4'h3, 1,32'h100,32'hDEAD_BEEF, 0,0, 0,0);
    tv[8]  = mk(0,0,4'h3, 0,32'h100,32'hDEAD_BEEF, 0,0,   0,0, 1,32'h100,32'hDEAD_BEEF,    0,0, 0,0);
    tv[9]  = mk(0,0,4'h3, 0,32'h100,32'hDEAD_BEEF, 1,32'h55, 0,0, 1,32'h100,32'hDEAD_BEEF, 0,0, 1,32'h55);
    tv[10] = mk(0,0,0, 0,0,0, 0,0,                        0,0, 0,0,0,                      0,0, 0,0);
    tv[11] = mk(4'h1,0,0, 32'h40,0,0, 0,0,                0,0, 0,0,0,                      0,0, 0,0);
    tv[12] = mk(4'h1,0,0, 32'h40,0,0, 1,32'h99,           4'h1,0, 1,32'h40,0,              0,0, 0,0);
    tv[13] = mk(4'h1,0,0, 32'h40,0,0, 0,0,                0,0, 1,32'h40,0,                 0,0, 0,0);
    tv[14] = mk(4'h1,0,0, 32'h40,0,0, 1,32'h77,           0,0, 1,32'h40,0,                 1,32'h77, 0,0);
    tv[15] = mk(0,0,0, 0,0,0, 0,0,                        0,0, 0,0,0,                      0,0, 0,0);
    tv[16] = mk(0,0,0, 0,0,0, 1,32'hAA,                   0,0, 0,0,0,                      0,0, 0,0);

    do_reset();
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      imem_rmask = tv[i].irm; dmem_rmask = tv[i].drm; dmem_wmask = tv[i].dwm;
      imem_addr = tv[i].ia; dmem_addr = tv[i].da; dmem_wdata = tv[i].dwd;
      mem_resp = tv[i].mr; mem_rdata = tv[i].mrd;
      #1;
      chk($sformatf("vec%0d_ctl", i),
          {mem_rmask, mem_wmask, imem_resp, imem_rdata, dmem_resp, dmem_rdata},
          {tv[i].erm, tv[i].ewm, tv[i].eir, tv[i].eird, tv[i].edr, tv[i].edrd});
      if (tv[i].ca)
        chk($sformatf("vec%0d_addr_wdata", i), {mem_addr, mem_wdata}, {tv[i].ea, tv[i].ewd});
    end

    // Both requesters pending continuously for four transactions
    `ifdef MEMARB_RR_EN
    exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01; exp_g[3] = 2'b10;
    `else
    exp_g[0] = 2'b01; exp_g[1] = 2'b01; exp_g[2] = 2'b01; exp_g[3] = 2'b01;
    `endif
    do_reset();
    @(negedge clk);
    imem_rmask = 4'hF; imem_addr = 32'h1000; dmem_rmask = 4'hF; dmem_addr = 32'h2000;
    for (int t = 0; t < 4; t++) begin
      wait_issue("tie");
      chk($sformatf("tie%0d_addr", t), mem_addr, exp_g[t][0] ? 32'h2000 : 32'h1000);
      @(negedge clk); mem_resp = 1'b1; mem_rdata = 32'h100 + t; #1;
      got_g = {imem_resp, dmem_resp};
      chk($sformatf("tie%0d_grant", t), got_g, exp_g[t]);
      @(negedge clk); mem_resp = 1'b0;
    end

    // Watchdog: no mem_resp for many WAIT cycles
    do_reset();
    @(negedge clk); dmem_rmask = 0; imem_rmask = 4'hF; imem_addr = 32'h3000;
    wait_issue("wdog");
    repeat (5) @(negedge clk);
    #1 chk("wdog_early", timeout_err, 1'b0);
    repeat (9) @(negedge clk);
    #1 chk("wdog_set", timeout_err, 1'b1);
    @(negedge clk); mem_resp = 1'b1; mem_rdata = 32'hBEEF; #1;
    chk("wdog_late_resp", {imem_resp, imem_rdata, dmem_resp}, {1'b1, 32'hBEEF, 1'b0});
    @(negedge clk); mem_resp = 1'b0; imem_rmask = 0;
    repeat (3) @(negedge clk);
    #1 chk("wdog_sticky", timeout_err, 1'b1);

    // Reset during WAIT, then a late mem_resp must be dropped
    do_reset();
    @(negedge clk); imem_rmask = 4'hF; imem_addr = 32'h4000;
    wait_issue("midrst");
    @(negedge clk); rst = 1'b0; imem_rmask = 0; #1;
    chk("midrst_outputs", {mem_rmask, imem_resp, dmem_resp}, 6'd0);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); mem_resp = 1'b1; mem_rdata = 32'h1234; #1;
    chk("midrst_late_resp", {imem_resp, dmem_resp, imem_rdata, dmem_rdata}, 66'd0);
    @(negedge clk); mem_resp = 1'b0; dmem_rmask = 4'hF; dmem_addr = 32'h300;
    wait_issue("postrst");
    chk("postrst_issue", {mem_addr, mem_rmask, mem_wmask}, {32'h300, 4'hF, 4'h0});
    @(negedge clk); mem_resp = 1'b1; mem_rdata = 32'hCAFE; #1;
    chk("postrst_resp", {dmem_resp, dmem_rdata, imem_resp}, {1'b1, 32'hCAFE, 1'b0});
    @(negedge clk); mem_resp = 1'b0; dmem_rmask = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
